// File: rtl/instr_loader_if.sv
// Instruction-memory write channel between loader and memory.
// master: wr_valid/wr_addr/wr_data out, wr_ready in; slave: mirror.
interface instr_loader_if #(
  parameter int AW     = 6,
  parameter int WORD_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [WORD_W-1:0] wr_data;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/instr_loader.sv
// Switch/button instruction loader: debounced buttons assemble a word
// from SW_W-bit chunks and write it to memory over the wr interface.
// Ports: clk, reset_n, sw, btn_sel/latch/commit/clear, wr (master),
// chunk_sel, latch_pulse, full, word_count.
module instr_loader #(
  parameter int SW_W       = 16,
  parameter int WORD_W     = 32,
  parameter int DEPTH      = 64,
  parameter int DEB_CYCLES = 16,
  parameter int WRAP       = 0,
  localparam int NCHUNK = WORD_W / SW_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SW_W-1:0]     sw,
  input  logic                btn_sel,
  input  logic                btn_latch,
  input  logic                btn_commit,
  input  logic                btn_clear,
  instr_loader_if.master      wr,
  output logic [CW-1:0]       chunk_sel,
  output logic                latch_pulse,
  output logic                full,
  output logic [AW:0]         word_count
);

  localparam int BW = $clog2(DEB_CYCLES);

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, nxt;

  // bit order: 0 sel, 1 latch, 2 commit, 3 clear
  logic [3:0]      raw, s1, s2, deb, press;
  logic [BW-1:0]   cnt [4];
  logic [SW_W-1:0] sw1, sw2;

  logic [AW-1:0]     addr;
  logic [WORD_W-1:0] asm_q;

  logic clr, commit_go, latch_go, sel_go, done, last;

  assign raw = {btn_clear, btn_commit, btn_latch, btn_sel};

  // level flips only after DEB_CYCLES cycles of a stable new value;
  // press pulses on the same edge the level rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      press <= '0;
      sw1   <= '0;
      sw2   <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      sw1 <= sw;
      sw2 <= sw1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == BW'(DEB_CYCLES - 1)) begin
          cnt[i]   <= '0;
          deb[i]   <= s2[i];
          press[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign clr       = press[3];
  assign commit_go = press[2] && !clr && (state == EDIT);
  assign latch_go  = press[1] && !press[2] && !clr
                     && (state != WRITE);
  assign sel_go    = press[0] && !press[1] && !press[2] && !clr
                     && (state != WRITE);
  assign done      = (state == WRITE) && wr.wr_ready && !clr;
  assign last      = (WRAP == 0)
                     && (word_count == (AW+1)'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EDIT;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      EDIT:    if (commit_go) nxt = WRITE;
      WRITE:   if (done) nxt = last ? FULL : EDIT;
      FULL:    nxt = FULL;
      default: nxt = EDIT;
    endcase
    if (clr) nxt = EDIT;
  end

  always_comb begin
    wr.wr_valid = (state == WRITE);
    full        = (state == FULL);
    wr.wr_addr  = addr;
    wr.wr_data  = asm_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= '0;
      word_count  <= '0;
      asm_q       <= '0;
      chunk_sel   <= '0;
      latch_pulse <= 1'b0;
    end else if (clr) begin
      addr        <= '0;
      word_count  <= '0;
      asm_q       <= '0;
      chunk_sel   <= '0;
      latch_pulse <= 1'b0;
    end else begin
      latch_pulse <= latch_go;
      if (done) begin
        if (word_count != (AW+1)'(DEPTH))
          word_count <= word_count + 1'b1;
        // without wrap the address parks on the last word
        if (!last) addr <= addr + 1'b1;
      end
      unique case (1'b1)
        latch_go: asm_q[chunk_sel*SW_W +: SW_W] <= sw2;
        sel_go:   chunk_sel <= (chunk_sel == CW'(NCHUNK - 1))
                               ? '0 : chunk_sel + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter SW_W, default 16, meaning switch bank width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, meaning instruction word width; integer multiple of SW_W.
REQ-003 SHALL have parameter DEPTH, default 64, meaning number of program words; power of two, at least 2.
REQ-004 SHALL have parameter DEB_CYCLES, default 16, meaning debounce stability count in clk cycles; at least 2.
REQ-005 SHALL have parameter WRAP, default 0, meaning 1 lets the write address wrap at DEPTH and 0 stops at full.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port sw, input, SW_W bits: switch data, treated as asynchronous.
REQ-009 SHALL have port btn_sel, input, 1 bit: raw button that advances the chunk select.
REQ-010 SHALL have port btn_latch, input, 1 bit: raw button that latches sw into the selected chunk.
REQ-011 SHALL have port btn_commit, input, 1 bit: raw button that writes the assembled word.
REQ-012 SHALL have port btn_clear, input, 1 bit: raw button that clears the address and the assembled word.
REQ-013 SHALL have port wr_valid, output, 1 bit: write request to the instruction memory.
REQ-014 SHALL have port wr_ready, input, 1 bit: the memory accepts the write.
REQ-015 SHALL have port wr_addr, output, log2(DEPTH) bits: word address of the write.
REQ-016 SHALL have port wr_data, output, WORD_W bits: the assembled instruction word.
REQ-017 SHALL have port chunk_sel, output, log2(NCHUNK) bits (minimum 1): the selected chunk, where NCHUNK = WORD_W/SW_W.
REQ-018 SHALL have port latch_pulse, output, 1 bit: high for one cycle after a latch.
REQ-019 SHALL have port full, output, 1 bit: all DEPTH words are written and WRAP = 0.
REQ-020 SHALL have port word_count, output, log2(DEPTH)+1 bits: the number of words committed since clear.

Function
REQ-021 SHALL pass each btn_* through a two-flop synchroniser followed by a debouncer; the debounced level changes only after the synchronised input holds a new value for DEB_CYCLES consecutive cycles.
REQ-022 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; holding a button SHALL produce no further pulses.
REQ-023 SHALL, on a sel press, increment chunk_sel modulo NCHUNK (NCHUNK-1 -> 0).
REQ-024 SHALL, on a latch press, load sw into bits [chunk_sel*SW_W +: SW_W] of the assembly register, leave the other chunks unchanged, and assert latch_pulse the following cycle.
REQ-025 SHALL keep wr_data equal to the assembly register at all times.
REQ-026 SHALL implement FSM states EDIT, WRITE and FULL; the reset state is EDIT.
REQ-027 SHALL, in EDIT on a commit press with full = 0, go to WRITE and assert wr_valid from the next cycle.
REQ-028 SHALL, in WRITE, hold wr_valid, wr_addr and wr_data stable until the cycle in which wr_ready = 1; the transfer completes in that cycle.
REQ-029 SHALL, on transfer completion: increment wr_addr (DEPTH-1 wraps to 0 when WRAP = 1), increment word_count (saturating at DEPTH), deassert wr_valid the next cycle, and return to EDIT.
REQ-030 SHALL, on completion with WRAP = 0 and word_count reaching DEPTH, go to FULL instead of EDIT, with full = 1 and wr_addr held at DEPTH-1.
REQ-031 SHALL, in FULL, ignore commit presses; sel and latch presses remain active.
REQ-032 SHALL ignore sel, latch and commit presses while in WRITE, so the data under transfer does not change.
REQ-033 SHALL, on a clear press in any state, zero wr_addr, word_count, the assembly register and chunk_sel, deassert wr_valid, and enter EDIT, aborting any pending write.
REQ-034 SHALL, when presses coincide in one cycle, apply priority clear > commit > latch > sel and drop the lower-priority presses.

Reset
REQ-035 SHALL, while reset_n = 0, asynchronously set all outputs and state to zero: wr_valid = 0, wr_addr = 0, wr_data = 0, chunk_sel = 0, latch_pulse = 0, full = 0, word_count = 0, FSM = EDIT, debounced levels = 0.
REQ-036 SHALL release reset synchronously, so the first state update occurs on the first rising clk edge after reset_n goes high; reset mid-WRITE drops the write.

Verification
REQ-037 Bench SHALL drive btn_latch with glitches shorter than DEB_CYCLES, then with a clean press -> only the clean press latches; exactly one latch_pulse.
REQ-038 Bench SHALL latch sw = 16'h1234 at chunk 0, press sel, latch 16'hABCD, then commit with wr_ready = 1 -> wr_data = 32'hABCD1234, wr_addr = 0, then wr_addr = 1 and word_count = 1.
REQ-039 Bench SHALL hold wr_ready = 0 for 5 cycles during WRITE while pressing latch -> wr_valid held, wr_data unchanged; completion occurs on the first cycle with wr_ready = 1.
REQ-040 Bench SHALL set DEPTH = 4, WRAP = 0, and commit 5 times -> full = 1 after the 4th commit, the 5th commit is ignored, and word_count = 4.
REQ-041 Bench SHALL set DEPTH = 4, WRAP = 1, and commit 5 times -> the 5th write goes to wr_addr = 0 and full stays 0.
REQ-042 Bench SHALL press clear and commit in the same cycle, and separately assert reset_n = 0 mid-WRITE -> no write occurs, wr_addr = 0, word_count = 0, and wr_valid = 0 immediately.
